// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the IF fetch port and the EXE data port.
// Requests pass through combinationally; an in-order ID FIFO steers each data_ok back to its issuer.
module mem_req_arbiter #(
  parameter int OUTS_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } gnt_e;

  gnt_e                  lock_q;
  gnt_e                  grant;
  logic [SW-1:0]         starve_q;
  logic [OUTS_DEPTH-1:0] id_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic granted_req;
  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic head_is_data;
  logic starve_max;

  assign full       = (count == CW'(OUTS_DEPTH));
  assign empty      = (count == '0);
  assign starve_max = (starve_q == SW'(STARVE_LIMIT));

  // A request already shown on the bus keeps the grant until taken or withdrawn.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = GNT_NONE;
    if (lock_q != GNT_NONE)         grant = lock_q;
    else if (starve_max && inst_req) grant = GNT_INST;
    else if (data_req)               grant = GNT_DATA;
    else if (inst_req)               grant = GNT_INST;
  end

  always_comb begin
    granted_req = 1'b0;
    case (grant)
      GNT_INST: granted_req = inst_req;
      GNT_DATA: granted_req = data_req;
      default:  granted_req = 1'b0;
    endcase
  end

  assign mem_req = granted_req & ~full;
  assign accept  = mem_req & mem_addr_ok;

  assign inst_addr_ok = accept & (grant == GNT_INST);
  assign data_addr_ok = accept & (grant == GNT_DATA);

  always_comb begin
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_wstrb = inst_wstrb;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (grant == GNT_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // While full, mem_req stays low, so the lock simply holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q <= GNT_NONE;
    end else if (accept) begin
      lock_q <= GNT_NONE;
    end else if (mem_req) begin
      lock_q <= grant;
    end else if (lock_q != GNT_NONE && !granted_req) begin
      lock_q <= GNT_NONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (inst_req && !inst_addr_ok) begin
      if (!starve_max) starve_q <= starve_q + 1'b1;
    end else begin
      starve_q <= '0;
    end
  end

  // A response arriving with nothing outstanding is dropped rather than popped.
  assign pop = mem_data_ok & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the ID storage has no reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr] <= (grant == GNT_DATA);
  end

  assign head_is_data = id_mem[rd_ptr];
  assign inst_data_ok = pop & ~head_is_data;
  assign data_data_ok = pop &  head_is_data;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

`ifndef SYNTHESIS
  a_no_orphan_data_ok : assert property (@(posedge clk) disable iff (!resetn) !(mem_data_ok && empty))
    else $error("mem_data_ok with no outstanding request");
`endif

endmodule
